// File: rtl/lc3x_muldiv_unit_pkg.sv
// Shared LC-3X types: MULT/DIV opcode select and the muldiv engine state encoding.
package lc3b_types;

    typedef enum logic {
        MULT = 1'b0,
        DIV  = 1'b1
    } lc3x_muldiv_op;

    // State literals carry an S_ prefix because DIV is already taken by the opcode enum.
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } lc3x_muldiv_state;

endpackage

// File: rtl/lc3x_muldiv_unit_divstep.sv
// One restoring-division step: shift in the next dividend bit, then subtract the
// divisor magnitude when that does not go negative.
module lc3x_divstep #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0] rem_in,
    input  logic [WIDTH:0] divisor,
    input  logic           dividend_bit,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];
    end

endmodule

// File: rtl/lc3x_muldiv_unit.sv
// Iterative signed 16-bit multiply/divide for the LC-3X EX stage: shift-add multiply,
// restoring divide on magnitudes with a sign fix-up pass.
module lc3x_muldiv_unit
    import lc3b_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  lc3x_muldiv_op    op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    lc3x_muldiv_state state, state_n;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, acc_n, mcand, mplier;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   prem, prem_n, dvs;
    logic             q_bit, q_neg, r_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
        acc_n = mplier[0] ? acc + mcand : acc;
    end

    // quo starts as |a| and shifts left; quotient bits fill in from the bottom.
    lc3x_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in      (prem),
        .divisor     (dvs),
        .dividend_bit(quo[WIDTH-1]),
        .rem_out     (prem_n),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == MULT)   state_n = S_MUL;
                    else if (b == '0) state_n = S_DONE;
                    else              state_n = S_DIV;
                end
            end
            S_MUL:   if (cnt == LAST) state_n = S_DONE;
            S_DIV:   if (cnt == LAST) state_n = S_FIX;
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            quo         <= '0;
            prem        <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            busy <= (state_n != S_IDLE);
            done <= (state_n == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        acc         <= '0;
                        mcand       <= a;
                        mplier      <= b;
                        quo         <= a_mag;
                        prem        <= '0;
                        dvs         <= {1'b0, b_mag};
                        q_neg       <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg       <= a[WIDTH-1];
                        if (op == DIV && b == '0) begin
                            result      <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= acc_n;
                        remainder <= '0;
                    end
                end
                S_DIV: begin
                    prem <= prem_n;
                    quo  <= {quo[WIDTH-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                end
                S_FIX: begin
                    result    <= q_neg ? -quo : quo;
                    remainder <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3x_muldiv_unit.sv
// Directed vector bench for lc3x_muldiv_unit: table of operations plus hand-written
// start-while-busy and reset-mid-divide sequences.
module tb_lc3x_muldiv_unit;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    lc3x_muldiv_op op_i;
    logic [15:0]   a_i, b_i;
    logic          busy, done, div_by_zero;
    logic [15:0]   result, remainder;

    int n_pass  = 0;
    int n_total = 0;

    lc3x_muldiv_unit #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op_i),
        .a          (a_i),
        .b          (b_i),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        lc3x_muldiv_op op;
        logic [15:0]   a;
        logic [15:0]   b;
        logic [15:0]   res;
        logic [15:0]   rem;
        logic          dz;
        int            cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Start in cycle 0, then sample each later cycle mid-period until done.
    task automatic run_op(input lc3x_muldiv_op op, input logic [15:0] a, input logic [15:0] b,
                          output int done_cyc, output logic [15:0] r, output logic [15:0] rm,
                          output logic dz, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start = 1'b0;
        op_i  = lc3x_muldiv_op'($urandom_range(0, 1));
        a_i   = 16'($urandom);
        b_i   = 16'($urandom);
        done_cyc = -1; busy_ok = 1'b1; r = '0; rm = '0; dz = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_cyc = c; r = result; rm = remainder; dz = div_by_zero;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc > 0) begin
            @(negedge clk);
            if (busy || done) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int          dc, first, second, ndone;
        logic [15:0] r, rm, r1, r2;
        logic        dz, bok, busy18, saw_done;

        vecs[0]  = '{"mul_7x6",      MULT, 16'd7,    16'd6,    16'h002A, 16'h0000, 1'b0, 17};
        vecs[1]  = '{"mul_m3x5",     MULT, 16'hFFFD, 16'd5,    16'hFFF1, 16'h0000, 1'b0, 17};
        vecs[2]  = '{"mul_wrap",     MULT, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[3]  = '{"mul_m1xm1",    MULT, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
        vecs[4]  = '{"div_100_7",    DIV,  16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 18};
        vecs[5]  = '{"div_m100_7",   DIV,  16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18};
        vecs[6]  = '{"div_100_m7",   DIV,  16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 18};
        vecs[7]  = '{"div_m100_m7",  DIV,  16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 18};
        vecs[8]  = '{"div_by_zero",  DIV,  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
        vecs[9]  = '{"div_ovf",      DIV,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
        vecs[10] = '{"div_8000_1",   DIV,  16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18};
        vecs[11] = '{"div_5_7",      DIV,  16'd5,    16'd7,    16'h0000, 16'h0005, 1'b0, 18};

        reset = 1'b1; start = 1'b0; op_i = MULT; a_i = '0; b_i = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, r, rm, dz, bok);
            chk({vecs[i].name, "_done_cycle"}, 32'(dc), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_result"}, 32'(r), 32'(vecs[i].res));
            chk({vecs[i].name, "_remainder"}, 32'(rm), 32'(vecs[i].rem));
            chk({vecs[i].name, "_dbz"}, 32'(dz), 32'(vecs[i].dz));
            chk({vecs[i].name, "_busy_window"}, 32'(bok), 32'd1);
        end

        // Start while busy: pulses in cycles 5 and 17 ignored, cycle 18 accepted.
        @(negedge clk);
        start = 1'b1; op_i = MULT; a_i = 16'd9; b_i = 16'd11;
        ndone = 0; first = -1; second = -1; r1 = '0; r2 = '0; busy18 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; r1 = result; end
                else if (second < 0) begin second = c; r2 = result; end
            end
            if (c == 18) busy18 = busy;
            start = (c == 5 || c == 17 || c == 18);
            if (c == 5 || c == 17) begin op_i = DIV; a_i = 16'h1111; b_i = 16'h0000; end
            else if (c == 18) begin op_i = MULT; a_i = 16'd2; b_i = 16'd3; end
        end
        chk("busy_start_first_done", 32'(first), 32'd17);
        chk("busy_start_result", 32'(r1), 32'h0063);
        chk("busy_start_idle_c18", 32'(busy18), 32'd0);
        chk("busy_start_second_done", 32'(second), 32'd35);
        chk("busy_start_second_result", 32'(r2), 32'h0006);
        chk("busy_start_done_count", 32'(ndone), 32'd2);

        // Leave non-zero outputs behind so the reset clear is visible.
        run_op(DIV, 16'hFF9C, 16'd7, dc, r, rm, dz, bok);
        chk("pre_rst_result", 32'(r), 32'hFFF2);
        chk("pre_rst_remainder", 32'(rm), 32'hFFFE);

        @(negedge clk);
        start = 1'b1; op_i = DIV; a_i = 16'd100; b_i = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_remainder", 32'(remainder), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);

        run_op(MULT, 16'd7, 16'd6, dc, r, rm, dz, bok);
        chk("post_rst_done_cycle", 32'(dc), 32'd17);
        chk("post_rst_result", 32'(r), 32'h002A);
        chk("post_rst_busy_window", 32'(bok), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
